// File: rtl/out_match_checker.sv
// Compares golden vs post-route netlist output buses a fixed settle time after each stimulus.
// Optional sticky per-bit difference mask enabled by OUT_MATCH_DIFF_MASK_EN.
module out_match_checker #(
  parameter int WIDTH         = 32,
  parameter int NUM_VECTORS   = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] netlist,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_mm_valid,
  output logic [CNT_W-1:0] first_mm_idx,
  output logic [WIDTH-1:0] first_mm_golden,
`ifdef OUT_MATCH_DIFF_MASK_EN
  output logic [WIDTH-1:0] first_mm_netlist,
  output logic [WIDTH-1:0] diff_mask
`else
  output logic [WIDTH-1:0] first_mm_netlist
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_VEC, SETTLE, COMPARE, DONE} state_t;

  localparam logic [CNT_W-1:0] NV       = CNT_W'(NUM_VECTORS);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] diff;
  logic             mm;
  logic [CNT_W-1:0] vec_nxt;
  logic [CNT_W-1:0] mm_nxt;

  always_comb begin
    diff    = golden ^ netlist;
    mm      = |diff;
    vec_nxt = vec_cnt + 1'b1;
    mm_nxt  = (mm && (mismatch_cnt != '1)) ? mismatch_cnt + 1'b1 : mismatch_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      vec_cnt          <= '0;
      mismatch_cnt     <= '0;
      first_mm_valid   <= 1'b0;
      first_mm_idx     <= '0;
      first_mm_golden  <= '0;
      first_mm_netlist <= '0;
`ifdef OUT_MATCH_DIFF_MASK_EN
      diff_mask        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= WAIT_VEC;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            vec_cnt          <= '0;
            mismatch_cnt     <= '0;
            first_mm_valid   <= 1'b0;
            first_mm_idx     <= '0;
            first_mm_golden  <= '0;
            first_mm_netlist <= '0;
`ifdef OUT_MATCH_DIFF_MASK_EN
            diff_mask        <= '0;
`endif
          end
        end
        WAIT_VEC: begin
          if (vec_valid) begin
            settle_cnt <= SETTLE_LD;
            state      <= (SETTLE_CYCLES == 1) ? COMPARE : SETTLE;
          end
        end
        SETTLE: begin
          // A fresh stimulus restarts the wait; only the newest one is compared.
          if (vec_valid) begin
            settle_cnt <= SETTLE_LD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
            if (settle_cnt == 4'd1) state <= COMPARE;
          end
        end
        COMPARE: begin
          vec_cnt      <= vec_nxt;
          mismatch_cnt <= mm_nxt;
`ifdef OUT_MATCH_DIFF_MASK_EN
          diff_mask    <= diff_mask | diff;
`endif
          if (mm && !first_mm_valid) begin
            first_mm_valid   <= 1'b1;
            first_mm_idx     <= vec_cnt;
            first_mm_golden  <= golden;
            first_mm_netlist <= netlist;
          end
          if (vec_nxt == NV) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mm_nxt == '0);
          end else begin
            state <= WAIT_VEC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/out_match_checker.md
Name: out_match_checker

Overview:
- Synthesizable result checker that sits directly downstream of the golden design and its post-route netlist.
- Consumes both 32-bit output buses, waits a programmable settle time after each applied stimulus, then compares them.
- Counts compared vectors and mismatches and captures the first failing vector.
- Reports pass/fail after a programmed number of vectors, so on-board and simulation runs give a self-checking verdict without a host.

Parameters:
- WIDTH, 32, width of the compared output buses.
- NUM_VECTORS, 1000, vectors to compare before reporting done.
- SETTLE_CYCLES, 2, clock cycles from vec_valid to the compare sample; legal range 1..15.
- CNT_W, 16, width of the vector and mismatch counters; must hold NUM_VECTORS.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset (reset when rst==0, sampled on the clk rising edge).
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- vec_valid  input  1  one-cycle pulse; a new stimulus was applied to both designs this cycle.
- golden  input  WIDTH  golden design output.
- netlist  input  WIDTH  post-route netlist output.
- busy  output  1  high from the cycle after start until done.
- done  output  1  high in DONE state; held until start or reset.
- pass  output  1  valid when done; 1 iff mismatch_cnt==0.
- vec_cnt  output  CNT_W  vectors compared in this run.
- mismatch_cnt  output  CNT_W  mismatching vectors; saturates at all-ones.
- first_mm_valid  output  1  a first mismatch has been captured.
- first_mm_idx  output  CNT_W  vec_cnt value (0-based) of the first mismatch.
- first_mm_golden  output  WIDTH  golden value at the first mismatch.
- first_mm_netlist  output  WIDTH  netlist value at the first mismatch.

Behaviour:
- Reset (rst==0): state=IDLE; every output and internal counter is 0, including busy, done, pass and all first_mm_* outputs.
- States: IDLE, WAIT_VEC, SETTLE, COMPARE, DONE.
- IDLE/DONE: on start, clear vec_cnt, mismatch_cnt, first_mm_* and pass; set busy=1, done=0; go to WAIT_VEC.
- WAIT_VEC: on vec_valid, load settle counter = SETTLE_CYCLES-1; go to SETTLE.
  - If SETTLE_CYCLES==1, go straight to COMPARE.
- SETTLE: decrement each cycle; at 0, go to COMPARE.
  - vec_valid arriving in SETTLE restarts the settle count; the newest stimulus wins and no extra vector is counted.
- COMPARE: takes one cycle. The sample is taken exactly SETTLE_CYCLES cycles after the vec_valid cycle.
  - mismatch = |(golden ^ netlist).
  - vec_cnt increments.
  - On mismatch, mismatch_cnt increments; it holds at all-ones once saturated.
  - On the first mismatch of a run, capture idx, golden and netlist; set first_mm_valid.
  - If the incremented vec_cnt == NUM_VECTORS, go to DONE; otherwise go to WAIT_VEC.
  - vec_valid in the COMPARE cycle is ignored.
- DONE: busy=0, done=1, pass = (mismatch_cnt==0). All outputs hold until start or reset.
- start while busy (WAIT_VEC, SETTLE or COMPARE) is ignored.
- vec_valid in IDLE or DONE is ignored.
- Reset mid-run returns to IDLE with everything cleared; no partial result is retained.
- Counters wrap only via start; vec_cnt never exceeds NUM_VECTORS.
- Comparison is pure 2-state XOR reduction. Unknown values are not modelled.

Optional Feature:
- Macro: OUT_MATCH_DIFF_MASK_EN.
- When defined:
  - Adds output diff_mask (WIDTH), reset 0 and cleared on start.
  - Every COMPARE cycle ORs golden^netlist into diff_mask, so it marks every bit that ever mismatched in the run.
  - The mask holds in DONE.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Equal buses, NUM_VECTORS=4, four vec_valid pulses with golden=netlist=32'hA5A5_0001.. -> done after the 4th compare, pass=1, vec_cnt=4, mismatch_cnt=0, first_mm_valid=0.
- Vector 2 (0-based) golden=32'h0000_00FF, netlist=32'h0000_00FE, rest equal -> mismatch_cnt=1, first_mm_idx=2, first_mm_golden=32'h0000_00FF, first_mm_netlist=32'h0000_00FE, pass=0; with the macro, diff_mask=32'h0000_0001.
- SETTLE_CYCLES=2; netlist changes from wrong to right one cycle after vec_valid -> sample taken on the 2nd cycle, no mismatch counted; a value that is wrong on the 2nd cycle is counted.
- Second vec_valid during SETTLE -> only one vector counted, and the compare occurs SETTLE_CYCLES after the second pulse.
- rst=0 for one cycle during SETTLE after 3 compares with 1 mismatch -> all outputs 0, state IDLE; a new start runs cleanly from vec_cnt=0.
- start pulsed while busy, and vec_valid pulsed in DONE -> no effect; counters and pass unchanged.
